cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Write-back, write-allocate miss controller that sequences one `cache_line` array between the pipeline's MEM stage and a handshaked word-wide main memory.
- Serves hits in the same cycle, stalls the pipeline on a miss, and drives line write-back and refill one word at a time.
- Also executes explicit line invalidations and keeps hit/miss performance counters.
- Sits between the MEM stage, the `cache_line` instance and the memory port.

Parameters:
- ADDR_W, 32, byte address width.
- TAG_W, 22, tag field = addr[31:10].
- IDX_W, 6, index field = addr[9:4].
- WORD_BITS, 2, word-in-line field = addr[3:2]; a line is 4 words (16 bytes).
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  access request; cpu_addr, cpu_we, cpu_din held stable while cpu_stall=1.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_inv  in  1  invalidate the line containing cpu_addr; takes priority over cpu_req.
- cpu_addr  in  32  byte address (bits 1:0 ignored).
- cpu_din  in  32  store data.
- cpu_dout  out  32  load data; valid when cpu_req & ~cpu_we & ~cpu_stall.
- cpu_stall  out  1  freeze pipeline.
- cache_addr  out  32  address to cache_line.
- cache_load  out  1  refill-write strobe (writes word, sets tag/valid, clears dirty).
- cache_edit  out  1  store-write strobe (writes word, sets dirty).
- cache_invalid  out  1  clear valid of the addressed line.
- cache_din  out  32  data to cache_line.
- cache_hit  in  1  combinational hit for cache_addr.
- cache_dout  in  32  combinational word at cache_addr index/word.
- cache_valid  in  1  line valid.
- cache_dirty  in  1  line dirty.
- cache_tag  in  22  stored tag of the indexed line.
- mem_cs  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  32  word-aligned memory address.
- mem_din  out  32  write data to memory.
- mem_dout  in  32  read data from memory.
- mem_ack  in  1  request completed this cycle.
- hit_cnt  out  32  number of hits.
- miss_cnt  out  32  number of misses.

Behaviour:
- States: IDLE, WB, FILL, INV. A 2-bit word counter `wcnt` drives line traversal.
- Reset values: state IDLE, wcnt 0, counters 0. All outputs 0, except cache_addr, which follows cpu_addr.
- IDLE hit path, cpu_req & ~cpu_inv & cache_hit:
  - cpu_stall=0.
  - Load: cpu_dout=cache_dout, zero latency.
  - Store: cache_edit=1 and cache_din=cpu_din for exactly that cycle.
  - hit_cnt increments.
- IDLE miss, cpu_req & ~cache_hit:
  - cpu_stall=1 combinationally; miss_cnt increments once.
  - If cache_valid & cache_dirty, go to WB; otherwise go to FILL. wcnt=0.
- WB:
  - mem_cs=1, mem_we=1.
  - mem_addr={cache_tag, idx, wcnt, 2'b00}.
  - cache_addr={cpu tag, idx, wcnt, 2'b00}; mem_din=cache_dout.
  - On mem_ack, wcnt++. Ack with wcnt=3 goes to FILL with wcnt=0.
- FILL:
  - mem_cs=1, mem_we=0.
  - mem_addr=cache_addr={cpu tag, idx, wcnt, 2'b00}.
  - On mem_ack: cache_load=1, cache_din=mem_dout, wcnt++. Ack with wcnt=3 goes to IDLE.
  - The request re-evaluates as a hit in the following cycle and is counted in hit_cnt too.
- Without mem_ack, WB/FILL hold every output and wcnt; there is no timeout.
- cpu_stall=1 in WB, FILL and INV, and on the IDLE miss/inv cycle.
- IDLE with cpu_inv: stall=1.
  - If cache_valid & cache_dirty & tag match, go to WB, then INV.
  - Otherwise go straight to INV.
- INV: one cycle, cache_invalid=1, then IDLE with stall released. Neither counter changes.
- A WB entered for invalidation goes to INV, not FILL; a one-bit `inv_pending` flag records this.
- cpu_req dropping mid-WB/FILL: the line transaction completes anyway; there are no partial lines.
- mem_ack in IDLE/INV is ignored.
- Counters wrap modulo 2^32.
- rst mid-transaction: state goes to IDLE and mem_cs drops immediately, with no handshake completion. Partially filled line contents are the cache's concern; cache_line has its own reset.

Decomposition:
- Package `cache_pkg`:
  - state encoding.
  - TAG/IDX/WORD field widths and bit offsets.
  - address compose/split helpers.
- Natural sub-module: `cache_perf_cnt` (two wrapping counters with increment enables). Everything else stays in cache_ctrl.

Test Plan:
1. rst pulsed asynchronously mid-cycle -> cpu_stall=0, mem_cs=0, hit_cnt=miss_cnt=0 immediately.
2. Clean read miss at 0x00000000; memory returns 0x11111111, ack every cycle -> reads 0x0, 0x4, 0x8, 0xC; four cache_load pulses; next cycle cpu_dout=0x11111111, stall=0; miss_cnt=1, hit_cnt=1.
3. Store hit at 0x00000008 with din 0x22222222 -> single cache_edit pulse, no stall, no mem_cs; hit_cnt=2.
4. Load at 0x00000408 (index 0, tag 1, line dirty) -> four writes to 0x0..0xC with 0x22222222 at 0x8, then four reads from 0x400..0x40C; miss_cnt=2.
5. mem_ack delayed 3 cycles per word during FILL -> mem_addr and wcnt hold; stall persists 16 cycles.
6. cpu_inv on a dirty line at 0x00000400 -> 4-word write-back, one cache_invalid pulse, then stall=0; a following load there misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address field helpers for the write-back cache miss controller.
package cache_pkg;

  localparam int ADDR_W    = 32;
  localparam int TAG_W     = 22;
  localparam int IDX_W     = 6;
  localparam int WORD_BITS = 2;
  localparam int CNT_W     = 32;

  localparam int WORD_LSB  = 2;
  localparam int IDX_LSB   = WORD_LSB + WORD_BITS;
  localparam int TAG_LSB   = IDX_LSB + IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    INV  = 2'd3
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[TAG_LSB +: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[IDX_LSB +: IDX_W];
  endfunction

  // Word-aligned byte address of one word inside a line.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]     tag,
                                                  input logic [IDX_W-1:0]     idx,
                                                  input logic [WORD_BITS-1:0] word);
    return {tag, idx, word, 2'b00};
  endfunction

endpackage

// File: rtl/cache_perf_cnt.sv
// Hit/miss performance counters; both wrap silently at 2^CNT_W.
module cache_perf_cnt
  import cache_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hit_inc,
  input  logic         miss_inc,
  output logic [W-1:0] hit_cnt,
  output logic [W-1:0] miss_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_inc)  hit_cnt  <= hit_cnt + 1'b1;
      if (miss_inc) miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Write-back, write-allocate miss controller between the MEM stage, one cache_line
// array and a handshaked word-wide memory; also runs explicit line invalidation.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_inv,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  output logic [31:0] cache_addr,
  output logic        cache_load,
  output logic        cache_edit,
  output logic        cache_invalid,
  output logic [31:0] cache_din,
  input  logic        cache_hit,
  input  logic [31:0] cache_dout,
  input  logic        cache_valid,
  input  logic        cache_dirty,
  input  logic [21:0] cache_tag,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_ack,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  state_t         state, state_nxt;
  logic [1:0]     wcnt, wcnt_nxt;
  logic           inv_pending, inv_pending_nxt;
  logic           hit_inc, miss_inc;

  logic [TAG_W-1:0] cpu_tag;
  logic [IDX_W-1:0] cpu_idx;
  logic             victim_dirty;
  logic             tag_match;

  assign cpu_tag      = addr_tag(cpu_addr);
  assign cpu_idx      = addr_idx(cpu_addr);
  assign victim_dirty = cache_valid & cache_dirty;
  assign tag_match    = (cache_tag == cpu_tag);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wcnt        <= '0;
      inv_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      inv_pending <= inv_pending_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    wcnt_nxt        = wcnt;
    inv_pending_nxt = inv_pending;
    unique case (state)
      IDLE: begin
        wcnt_nxt = '0;
        if (cpu_inv) begin
          // Only a dirty copy of this exact line needs saving before it is dropped.
          if (victim_dirty && tag_match) begin
            state_nxt       = WB;
            inv_pending_nxt = 1'b1;
          end else begin
            state_nxt = INV;
          end
        end else if (cpu_req && !cache_hit) begin
          inv_pending_nxt = 1'b0;
          state_nxt       = victim_dirty ? WB : FILL;
        end
      end
      WB: begin
        if (mem_ack) begin
          wcnt_nxt = wcnt + 2'd1;
          if (wcnt == 2'd3) state_nxt = inv_pending ? INV : FILL;
        end
      end
      FILL: begin
        if (mem_ack) begin
          wcnt_nxt = wcnt + 2'd1;
          if (wcnt == 2'd3) state_nxt = IDLE;
        end
      end
      INV: begin
        state_nxt       = IDLE;
        inv_pending_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cpu_dout      = '0;
    cpu_stall     = 1'b0;
    cache_addr    = cpu_addr;
    cache_load    = 1'b0;
    cache_edit    = 1'b0;
    cache_invalid = 1'b0;
    cache_din     = '0;
    mem_cs        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_din       = '0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    // Outputs are quiet while reset is held, even with a request pending.
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (cpu_inv) begin
            cpu_stall = 1'b1;
          end else if (cpu_req) begin
            if (cache_hit) begin
              hit_inc = 1'b1;
              if (cpu_we) begin
                cache_edit = 1'b1;
                cache_din  = cpu_din;
              end else begin
                cpu_dout = cache_dout;
              end
            end else begin
              cpu_stall = 1'b1;
              miss_inc  = 1'b1;
            end
          end
        end
        WB: begin
          cpu_stall  = 1'b1;
          mem_cs     = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = line_addr(cache_tag, cpu_idx, wcnt);
          cache_addr = line_addr(cpu_tag, cpu_idx, wcnt);
          mem_din    = cache_dout;
        end
        FILL: begin
          cpu_stall  = 1'b1;
          mem_cs     = 1'b1;
          mem_addr   = line_addr(cpu_tag, cpu_idx, wcnt);
          cache_addr = line_addr(cpu_tag, cpu_idx, wcnt);
          if (mem_ack) begin
            cache_load = 1'b1;
            cache_din  = mem_dout;
          end
        end
        INV: begin
          cpu_stall     = 1'b1;
          cache_invalid = 1'b1;
        end
        default: cpu_stall = 1'b0;
      endcase
    end
  end

  cache_perf_cnt #(.W(CNT_W)) u_perf (
    .clk      (clk),
    .rst      (rst),
    .hit_inc  (hit_inc),
    .miss_inc (miss_inc),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with behavioural cache_line and word memory models.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_inv;
  logic [31:0] cpu_addr, cpu_din, cpu_dout;
  logic        cpu_stall;
  logic [31:0] cache_addr, cache_din, cache_dout;
  logic        cache_load, cache_edit, cache_invalid;
  logic        cache_hit, cache_valid, cache_dirty;
  logic [21:0] cache_tag;
  logic        mem_cs, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic [31:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_inv(cpu_inv),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .cache_addr(cache_addr), .cache_load(cache_load), .cache_edit(cache_edit),
    .cache_invalid(cache_invalid), .cache_din(cache_din), .cache_hit(cache_hit),
    .cache_dout(cache_dout), .cache_valid(cache_valid), .cache_dirty(cache_dirty),
    .cache_tag(cache_tag),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // cache_line model: 64 lines x 4 words, combinational lookup at cache_addr.
  logic        c_valid [64];
  logic        c_dirty [64];
  logic [21:0] c_tag   [64];
  logic [31:0] c_data  [64][4];
  logic [5:0]  ci;
  logic [1:0]  cw;
  assign ci          = cache_addr[9:4];
  assign cw          = cache_addr[3:2];
  assign cache_valid = c_valid[ci];
  assign cache_dirty = c_dirty[ci];
  assign cache_tag   = c_tag[ci];
  assign cache_dout  = c_data[ci][cw];
  assign cache_hit   = c_valid[ci] && (c_tag[ci] == cache_addr[31:10]);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        c_valid[i] <= 1'b0;
        c_dirty[i] <= 1'b0;
        c_tag[i]   <= '0;
        for (int j = 0; j < 4; j++) c_data[i][j] <= '0;
      end
    end else begin
      if (cache_load) begin
        c_data[ci][cw] <= cache_din;
        c_tag[ci]      <= cache_addr[31:10];
        c_valid[ci]    <= 1'b1;
        c_dirty[ci]    <= 1'b0;
      end
      if (cache_edit) begin
        c_data[ci][cw] <= cache_din;
        c_dirty[ci]    <= 1'b1;
      end
      if (cache_invalid) c_valid[ci] <= 1'b0;
    end
  end

  // Memory model: 1K words, default 0x11111111, line 0x400 preloaded with A000000n.
  logic [31:0] mem [1024];
  int          ack_delay = 0;
  int          wait_cnt;
  assign mem_ack  = mem_cs && (wait_cnt == ack_delay);
  assign mem_dout = (mem_cs && !mem_we) ? mem[mem_addr[11:2]] : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 0;
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h1111_1111;
      for (int i = 0; i < 4; i++)    mem[256 + i] <= 32'hA000_0000 + 32'(i);
    end else begin
      if (mem_cs) wait_cnt <= mem_ack ? 0 : wait_cnt + 1;
      else        wait_cnt <= 0;
      if (mem_cs && mem_ack && mem_we) mem[mem_addr[11:2]] <= mem_din;
    end
  end

  // Cumulative event monitors; tests work on deltas.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;
  xfer_t       log_q [$];
  int          load_cnt = 0, edit_cnt = 0, inv_cnt = 0, rd_cycles = 0, hold_err = 0;
  logic        held = 1'b0;
  logic [31:0] held_addr = '0;

  always @(posedge clk) begin
    if (mem_cs && mem_ack) log_q.push_back({mem_we, mem_addr, mem_we ? mem_din : mem_dout});
    if (cache_load)    load_cnt++;
    if (cache_edit)    edit_cnt++;
    if (cache_invalid) inv_cnt++;
    if (mem_cs && !mem_we) rd_cycles++;
    if (held && mem_cs && (mem_addr !== held_addr)) hold_err++;
    held      = mem_cs && !mem_ack;
    held_addr = mem_addr;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One pipeline access: hold the request until a falling edge shows no stall,
  // then let the following rising edge commit it.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] din,
                        output logic [31:0] dout, output int stalls, output logic done);
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = addr;
    cpu_din  = din;
    stalls   = 0;
    done     = 1'b0;
    dout     = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!cpu_stall) begin
        done = 1'b1;
        dout = cpu_dout;
        break;
      end
      stalls++;
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic do_inv(input logic [31:0] addr, output int stalls, output logic seen);
    cpu_inv  = 1'b1;
    cpu_addr = addr;
    stalls   = 0;
    seen     = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cache_invalid) begin
        seen = 1'b1;
        break;
      end
      if (cpu_stall) stalls++;
    end
    @(posedge clk);
    #1;
    cpu_inv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] dout;
  int          stalls, base, ld0, ed0, iv0, rd0, he0;
  logic        done;
  logic [31:0] wb_addr [8];
  logic [31:0] wb_data [8];
  logic        wb_we   [8];
  logic [31:0] iv_data [4];

  initial begin
    wb_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h400, 32'h404, 32'h408, 32'h40C};
    wb_data = '{32'h1111_1111, 32'h1111_1111, 32'h2222_2222, 32'h1111_1111,
                32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    wb_we   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    iv_data = '{32'h3333_3333, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_inv = 1'b0;
    cpu_addr = 32'h1234_5678; cpu_din = '0;
    #2;
    check("rst_stall", {31'b0, cpu_stall}, 32'd0);
    check("rst_mem_cs", {31'b0, mem_cs}, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    check("rst_cache_addr", cache_addr, 32'h1234_5678);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a stalled refill.
    ack_delay = 100;
    cpu_req = 1'b1; cpu_addr = 32'h0;
    repeat (3) @(negedge clk);
    check("fill_stall", {31'b0, cpu_stall}, 32'd1);
    check("fill_mem_cs", {31'b0, mem_cs}, 32'd1);
    check("fill_miss_cnt", miss_cnt, 32'd1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_stall", {31'b0, cpu_stall}, 32'd0);
    check("async_rst_mem_cs", {31'b0, mem_cs}, 32'd0);
    check("async_rst_miss_cnt", miss_cnt, 32'd0);
    check("async_rst_hit_cnt", hit_cnt, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    @(posedge clk);
    #1;

    // Clean read miss at 0x0: 1 miss cycle + 4 refill cycles.
    base = log_q.size(); ld0 = load_cnt;
    access(1'b0, 32'h0, 32'h0, dout, stalls, done);
    check("t2_done", {31'b0, done}, 32'd1);
    check("t2_dout", dout, 32'h1111_1111);
    check("t2_stalls", 32'(stalls), 32'd5);
    check("t2_loads", 32'(load_cnt - ld0), 32'd4);
    check("t2_xfers", 32'(log_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t2_rd_addr", log_q[base + i].addr, 32'(4 * i));
      check("t2_rd_we", {31'b0, log_q[base + i].we}, 32'd0);
    end
    check("t2_miss_cnt", miss_cnt, 32'd1);
    check("t2_hit_cnt", hit_cnt, 32'd1);

    // Store hit.
    base = log_q.size(); ed0 = edit_cnt;
    access(1'b1, 32'h8, 32'h2222_2222, dout, stalls, done);
    check("t3_stalls", 32'(stalls), 32'd0);
    check("t3_edits", 32'(edit_cnt - ed0), 32'd1);
    check("t3_xfers", 32'(log_q.size() - base), 32'd0);
    check("t3_hit_cnt", hit_cnt, 32'd2);

    // Dirty conflict: write back line 0 tag 0, refill tag 1.
    base = log_q.size();
    access(1'b0, 32'h408, 32'h0, dout, stalls, done);
    check("t4_done", {31'b0, done}, 32'd1);
    check("t4_stalls", 32'(stalls), 32'd9);
    check("t4_dout", dout, 32'hA000_0002);
    check("t4_xfers", 32'(log_q.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("t4_addr", log_q[base + i].addr, wb_addr[i]);
      check("t4_data", log_q[base + i].data, wb_data[i]);
      check("t4_we", {31'b0, log_q[base + i].we}, {31'b0, wb_we[i]});
    end
    check("t4_miss_cnt", miss_cnt, 32'd2);
    check("t4_hit_cnt", hit_cnt, 32'd3);

    // Slow memory: 3 wait cycles per word -> 16 refill cycles plus the miss cycle.
    ack_delay = 3;
    rd0 = rd_cycles; he0 = hold_err; ld0 = load_cnt;
    access(1'b0, 32'h10, 32'h0, dout, stalls, done);
    check("t5_done", {31'b0, done}, 32'd1);
    check("t5_stalls", 32'(stalls), 32'd17);
    check("t5_rd_cycles", 32'(rd_cycles - rd0), 32'd16);
    check("t5_addr_hold", 32'(hold_err - he0), 32'd0);
    check("t5_loads", 32'(load_cnt - ld0), 32'd4);
    check("t5_dout", dout, 32'h1111_1111);
    check("t5_miss_cnt", miss_cnt, 32'd3);
    ack_delay = 0;

    // Dirty line at 0x400, then invalidate it.
    access(1'b1, 32'h400, 32'h3333_3333, dout, stalls, done);
    check("t6_store_stalls", 32'(stalls), 32'd0);
    check("t6_hit_cnt", hit_cnt, 32'd5);
    base = log_q.size(); iv0 = inv_cnt;
    do_inv(32'h400, stalls, done);
    check("t6_inv_seen", {31'b0, done}, 32'd1);
    check("t6_inv_stalls", 32'(stalls), 32'd5);
    check("t6_wb_xfers", 32'(log_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t6_wb_addr", log_q[base + i].addr, 32'h400 + 32'(4 * i));
      check("t6_wb_data", log_q[base + i].data, iv_data[i]);
    end
    check("t6_inv_pulses", 32'(inv_cnt - iv0), 32'd1);
    @(negedge clk);
    check("t6_stall_released", {31'b0, cpu_stall}, 32'd0);
    check("t6_hit_unchanged", hit_cnt, 32'd5);
    check("t6_miss_unchanged", miss_cnt, 32'd3);
    @(posedge clk);
    #1;
    base = log_q.size();
    access(1'b0, 32'h400, 32'h0, dout, stalls, done);
    check("t6_reload_stalls", 32'(stalls), 32'd5);
    check("t6_reload_first_we", {31'b0, log_q[base].we}, 32'd0);
    check("t6_reload_dout", dout, 32'h3333_3333);
    check("t6_reload_miss_cnt", miss_cnt, 32'd4);
    check("t6_reload_hit_cnt", hit_cnt, 32'd6);

    // Invalidate a clean line: no write-back, straight to INV.
    base = log_q.size(); iv0 = inv_cnt;
    do_inv(32'h10, stalls, done);
    check("t7_inv_seen", {31'b0, done}, 32'd1);
    check("t7_inv_stalls", 32'(stalls), 32'd1);
    check("t7_xfers", 32'(log_q.size() - base), 32'd0);
    check("t7_inv_pulses", 32'(inv_cnt - iv0), 32'd1);
    access(1'b0, 32'h10, 32'h0, dout, stalls, done);
    check("t7_reload_miss_cnt", miss_cnt, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
